// File: rtl/timer_channel_ctrl_pkg.sv
// Shared types and helpers for one 8253-style timer channel:
// counting modes, read/write format codes, sequencer states.
package timer_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    MODE_ONESHOT = 2'd0,
    MODE_PER1    = 2'd1,
    MODE_PER2    = 2'd2
  } mode_e;

  localparam logic [1:0] RW_LATCH = 2'b00;
  localparam logic [1:0] RW_LSB   = 2'b01;
  localparam logic [1:0] RW_MSB   = 2'b10;
  localparam logic [1:0] RW_WORD  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_MSB,
    ST_ARMED,
    ST_COUNTING,
    ST_DONE
  } state_e;

  // The highest set bit of the mode field wins; unused encodings collapse onto these three.
  function automatic mode_e decode_mode(input logic [2:0] field);
    mode_e m;
    if (field[2])      m = MODE_PER1;
    else if (field[1]) m = MODE_PER2;
    else               m = MODE_ONESHOT;
    return m;
  endfunction

endpackage

// File: rtl/timer_channel_ctrl_byte_io.sv
// Byte-wide bus side of a timer channel: write/read byte pointers,
// reload assembly, count latch and the registered read mux.
module timer_byte_io
  import timer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ctrl_clear,
  input  logic             latch_cmd,
  input  logic [1:0]       rw,
  input  logic             data_we,
  input  logic [7:0]       data_in,
  input  logic             rd_re,
  input  logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] reload,
  output logic             load_lsb,
  output logic             load_final,
  output logic [7:0]       data_out
);

  logic             wr_msb;
  logic             rd_msb;
  logic             latch_full;
  logic [7:0]       lsb_hold;
  logic [CNT_W-1:0] latch_val;
  logic [CNT_W-1:0] rd_src;
  logic [7:0]       rd_byte;
  logic             rd_last;

  always_comb begin
    load_lsb   = data_we && (rw == RW_WORD) && !wr_msb;
    load_final = data_we && ((rw != RW_WORD) || wr_msb);
    rd_src     = latch_full ? latch_val : count;
    rd_byte    = rd_src[7:0];
    rd_last    = 1'b1;
    case (rw)
      RW_LSB: rd_byte = rd_src[7:0];
      RW_MSB: rd_byte = rd_src[CNT_W-1:8];
      default: begin
        rd_byte = rd_msb ? rd_src[CNT_W-1:8] : rd_src[7:0];
        rd_last = rd_msb;
      end
    endcase
  end

  // A pending latch is only released once its final byte has been read out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_msb     <= 1'b0;
      rd_msb     <= 1'b0;
      latch_full <= 1'b0;
      lsb_hold   <= '0;
      latch_val  <= '0;
      reload     <= '0;
      data_out   <= '0;
    end else begin
      if (rd_re) data_out <= rd_byte;
      if (ctrl_clear) begin
        wr_msb     <= 1'b0;
        rd_msb     <= 1'b0;
        latch_full <= 1'b0;
      end else begin
        if (load_lsb) begin
          lsb_hold <= data_in;
          wr_msb   <= 1'b1;
        end else if (load_final) begin
          wr_msb <= 1'b0;
          case (rw)
            RW_LSB:  reload <= {8'h00, data_in};
            RW_MSB:  reload <= {data_in, 8'h00};
            default: reload <= {data_in, lsb_hold};
          endcase
        end
        if (rd_re && (rw == RW_WORD)) rd_msb <= ~rd_msb;
        if (latch_cmd && !latch_full) begin
          latch_val  <= count;
          latch_full <= 1'b1;
        end else if (rd_re && latch_full && rd_last) begin
          latch_full <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/timer_channel_ctrl.sv
// One 8253-style timer channel: control word handling, load/arm/count
// sequencing of the 16-bit down-counter and the channel output.
module timer_channel_ctrl
  import timer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ctrl_we,
  input  logic [2:0]       ctrl_mode,
  input  logic [1:0]       ctrl_rw,
  input  logic             data_we,
  input  logic [7:0]       data_in,
  input  logic             rd_re,
  output logic [7:0]       data_out,
  input  logic             gate,
  input  logic             tick,
  output logic             out,
  output logic [CNT_W-1:0] count,
  output logic             busy
);

  mode_e            mode;
  mode_e            new_mode;
  state_e           state;
  logic [1:0]       rw;
  logic             gate_q;
  logic             reload_pending;
  logic [CNT_W-1:0] reload;
  logic [CNT_W-1:0] reload_eff;
  logic             ctrl_cfg;
  logic             latch_cmd;
  logic             data_wr;
  logic             load_lsb;
  logic             load_final;
  logic             per_mode;
  logic             counted;
  logic             pending_now;
  logic             hold_run;

  assign ctrl_cfg  = ctrl_we && (ctrl_rw != RW_LATCH);
  assign latch_cmd = ctrl_we && (ctrl_rw == RW_LATCH);
  assign data_wr   = data_we && !ctrl_we;
  assign busy      = (state == ST_ARMED) || (state == ST_COUNTING);

  timer_byte_io u_byte_io (
    .clk        (clk),
    .rst_n      (rst_n),
    .ctrl_clear (ctrl_cfg),
    .latch_cmd  (latch_cmd),
    .rw         (rw),
    .data_we    (data_wr),
    .data_in    (data_in),
    .rd_re      (rd_re),
    .count      (count),
    .reload     (reload),
    .load_lsb   (load_lsb),
    .load_final (load_final),
    .data_out   (data_out)
  );

  // Periodic modes cannot run with a period of one, so a reload of 1 behaves as 2.
  always_comb begin
    new_mode    = decode_mode(ctrl_mode);
    per_mode    = (mode != MODE_ONESHOT);
    counted     = tick && gate;
    pending_now = reload_pending || (per_mode && gate && !gate_q);
    reload_eff  = (per_mode && (reload == CNT_W'(1))) ? CNT_W'(2) : reload;
    hold_run    = per_mode && (state == ST_COUNTING);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode           <= MODE_ONESHOT;
      rw             <= RW_WORD;
      state          <= ST_IDLE;
      count          <= '0;
      out            <= 1'b0;
      gate_q         <= 1'b0;
      reload_pending <= 1'b0;
    end else begin
      gate_q <= gate;
      if (ctrl_cfg) begin
        mode           <= new_mode;
        rw             <= ctrl_rw;
        state          <= ST_IDLE;
        out            <= (new_mode != MODE_ONESHOT);
        reload_pending <= 1'b0;
      end else begin
        reload_pending <= pending_now;
        if (counted && (state == ST_ARMED)) begin
          count          <= reload_eff;
          state          <= ST_COUNTING;
          reload_pending <= 1'b0;
        end else if (counted && (state == ST_COUNTING)) begin
          if (mode == MODE_PER1) out <= 1'b1;
          if (pending_now) begin
            count          <= reload_eff;
            reload_pending <= 1'b0;
          end else if (count == CNT_W'(1)) begin
            case (mode)
              MODE_PER1: begin
                count <= reload_eff;
                out   <= 1'b0;
              end
              MODE_PER2: begin
                count <= reload_eff;
                out   <= ~out;
              end
              default: begin
                count <= '0;
                out   <= 1'b1;
                state <= ST_DONE;
              end
            endcase
          end else begin
            count <= count - CNT_W'(1);
          end
        end
        if (per_mode && !gate) out <= 1'b1;
        // A running periodic count is never interrupted by a new load.
        if (load_lsb && !hold_run) state <= ST_WAIT_MSB;
        if (load_final) begin
          if (!hold_run) state <= ST_ARMED;
          if (!per_mode) out <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_timer_channel_ctrl.sv
// Self-checking bench for timer_channel_ctrl: directed scenarios plus random
// bus/tick traffic compared every cycle against an elapsed-tick reference model.
module tb_timer_channel_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ctrl_we;
  logic [2:0]  ctrl_mode;
  logic [1:0]  ctrl_rw;
  logic        data_we;
  logic [7:0]  data_in;
  logic        rd_re;
  logic [7:0]  data_out;
  logic        gate;
  logic        tick;
  logic        out;
  logic [15:0] count;
  logic        busy;

  int checks = 0;
  int failures = 0;
  bit check_each = 1'b1;

  localparam int PH_IDLE = 0, PH_WAIT = 1, PH_ARMED = 2, PH_CNT = 3, PH_DONE = 4;

  int          m_mode;
  int          m_phase;
  int          m_t;
  int          m_n;
  logic [1:0]  m_rw;
  logic [15:0] m_reload, m_count, m_latch;
  logic [7:0]  m_lsb, m_dout;
  bit          m_wptr, m_rptr, m_latch_full, m_out, m_pending, m_gprev;

  int exp3_count[9] = '{3, 2, 1, 3, 2, 1, 3, 2, 1};
  bit exp3_out[9]   = '{1, 1, 1, 0, 1, 1, 0, 1, 1};

  timer_channel_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ctrl_we   (ctrl_we),
    .ctrl_mode (ctrl_mode),
    .ctrl_rw   (ctrl_rw),
    .data_we   (data_we),
    .data_in   (data_in),
    .rd_re     (rd_re),
    .data_out  (data_out),
    .gate      (gate),
    .tick      (tick),
    .out       (out),
    .count     (count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  function automatic int decodeModel(input logic [2:0] cm);
    if (cm[2]) return 1;
    if (cm[1]) return 2;
    return 0;
  endfunction

  // Ticks in one period: a zero load means 65536, periodic modes never use 1.
  function automatic int periodLen(input int md, input logic [15:0] r);
    int n;
    n = (r == 16'd0) ? 65536 : int'(r);
    if (md != 0 && n == 1) n = 2;
    return n;
  endfunction

  task automatic modelReset();
    m_mode = 0; m_rw = 2'b11; m_phase = PH_IDLE; m_t = 0; m_n = 0;
    m_reload = '0; m_count = '0; m_latch = '0; m_lsb = '0; m_dout = '0;
    m_wptr = 0; m_rptr = 0; m_latch_full = 0; m_out = 0; m_pending = 0; m_gprev = 0;
  endtask

  task automatic modelStep(input bit cw, input logic [2:0] cm, input logic [1:0] crw, input bit dw,
                           input logic [7:0] din, input bit rr, input bit g, input bit tk);
    bit per, full_pre, emptied, first_byte, counted, pend;
    int phase_pre;
    logic [15:0] src;
    per = (m_mode != 0);
    full_pre = m_latch_full;
    phase_pre = m_phase;
    emptied = 0;
    if (rr) begin
      src = m_latch_full ? m_latch : m_count;
      if (m_rw == 2'b01) begin
        m_dout = src[7:0]; emptied = full_pre;
      end else if (m_rw == 2'b10) begin
        m_dout = src[15:8]; emptied = full_pre;
      end else begin
        m_dout = m_rptr ? src[15:8] : src[7:0];
        emptied = full_pre && m_rptr;
        m_rptr = !m_rptr;
      end
    end
    if (cw && crw == 2'b00 && !full_pre) begin
      m_latch = m_count; m_latch_full = 1;
    end else if (emptied) begin
      m_latch_full = 0;
    end
    if (cw && crw != 2'b00) begin
      m_mode = decodeModel(cm); m_rw = crw; m_phase = PH_IDLE;
      m_wptr = 0; m_rptr = 0; m_latch_full = 0; m_out = (m_mode != 0); m_pending = 0;
    end else begin
      counted = g && tk;
      pend = m_pending || (per && g && !m_gprev);
      if (counted && phase_pre == PH_ARMED) begin
        m_n = periodLen(m_mode, m_reload); m_t = 0; m_phase = PH_CNT; pend = 0;
        m_count = 16'(m_n - m_t);
      end else if (counted && phase_pre == PH_CNT) begin
        if (m_mode == 1) m_out = 1;
        if (per && pend) begin
          m_n = periodLen(m_mode, m_reload); m_t = 0; pend = 0;
        end else begin
          m_t++;
          if (m_t == m_n) begin
            if (m_mode == 0) begin
              m_out = 1; m_phase = PH_DONE;
            end else begin
              m_t = 0; m_n = periodLen(m_mode, m_reload);
              m_out = (m_mode == 1) ? 1'b0 : !m_out;
            end
          end
        end
        m_count = 16'(m_n - m_t);
      end
      m_pending = pend;
      if (per && !g) m_out = 1;
      if (dw) begin
        first_byte = (m_rw == 2'b11) && !m_wptr;
        if (first_byte) begin
          m_lsb = din; m_wptr = 1;
        end else begin
          m_wptr = 0;
          if (m_rw == 2'b01)      m_reload = {8'h00, din};
          else if (m_rw == 2'b10) m_reload = {din, 8'h00};
          else                    m_reload = {din, m_lsb};
          if (!per) m_out = 0;
        end
        if (!(per && phase_pre == PH_CNT)) m_phase = first_byte ? PH_WAIT : PH_ARMED;
      end
    end
    m_gprev = g;
  endtask

  task automatic applyStimulus(input bit cw, input logic [2:0] cm, input logic [1:0] crw, input bit dw,
                               input logic [7:0] din, input bit rr, input bit tk);
    ctrl_we = cw; ctrl_mode = cm; ctrl_rw = crw; data_we = dw; data_in = din; rd_re = rr; tick = tk;
    modelStep(cw, cm, crw, dw, din, rr, gate, tk);
    @(posedge clk);
    #1;
    ctrl_we = 0; data_we = 0; rd_re = 0; tick = 0;
    if (check_each) begin
      checkOutput("cyc_count", count, m_count);
      checkOutput("cyc_out", out, m_out);
      checkOutput("cyc_busy", busy, (m_phase == PH_ARMED) || (m_phase == PH_CNT));
      checkOutput("cyc_data_out", data_out, m_dout);
    end
  endtask

  task automatic doCtrl(input logic [2:0] md, input logic [1:0] rw);
    applyStimulus(1, md, rw, 0, 8'h00, 0, 0);
  endtask

  task automatic doData(input logic [7:0] b);
    applyStimulus(0, 3'b000, 2'b00, 1, b, 0, 0);
  endtask

  task automatic doRead();
    applyStimulus(0, 3'b000, 2'b00, 0, 8'h00, 1, 0);
  endtask

  task automatic doIdle();
    applyStimulus(0, 3'b000, 2'b00, 0, 8'h00, 0, 0);
  endtask

  task automatic doTick(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 3'b000, 2'b00, 0, 8'h00, 0, 1);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired before the end of the run");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit          r_cw, r_dw, r_rr, r_tk;
    logic [2:0]  r_cm;
    logic [1:0]  r_rw;
    logic [7:0]  r_din;

    rst_n = 0; ctrl_we = 0; ctrl_mode = '0; ctrl_rw = '0; data_we = 0; data_in = '0;
    rd_re = 0; gate = 1; tick = 0;
    modelReset();
    #12;
    checkOutput("rst_count", count, 16'h0000);
    checkOutput("rst_out", out, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_data_out", data_out, 8'h00);
    #5 rst_n = 1;
    @(posedge clk);
    #1;

    $display("[TB] oneshot load 5");
    doCtrl(3'b000, 2'b11);
    doData(8'h05);
    doData(8'h00);
    checkOutput("t2_busy_armed", busy, 1'b1);
    for (int i = 0; i < 6; i++) begin
      doTick(1);
      checkOutput("t2_count", count, 32'(5 - i));
      if (i < 5) checkOutput("t2_out_low", out, 1'b0);
    end
    checkOutput("t2_out_term", out, 1'b1);
    checkOutput("t2_busy_done", busy, 1'b0);
    doTick(1);
    checkOutput("t2_done_count", count, 16'h0000);
    checkOutput("t2_done_out", out, 1'b1);

    $display("[TB] rate mode load 3");
    doCtrl(3'b100, 2'b11);
    doData(8'h03);
    doData(8'h00);
    for (int i = 0; i < 9; i++) begin
      doTick(1);
      checkOutput("t3_count", count, exp3_count[i]);
      checkOutput("t3_out", out, exp3_out[i]);
    end

    $display("[TB] square mode load 4 with gate");
    doCtrl(3'b010, 2'b01);
    doData(8'h04);
    for (int k = 1; k <= 16; k++) begin
      doTick(1);
      checkOutput("t4_out", out, (((k - 1) / 4) % 2) == 0);
    end
    checkOutput("t4_count16", count, 16'd1);
    gate = 0;
    doIdle();
    checkOutput("t4_gate_out", out, 1'b1);
    doTick(3);
    checkOutput("t4_frozen", count, 16'd1);
    gate = 1;
    doIdle();
    doTick(1);
    checkOutput("t4_reload", count, 16'd4);
    checkOutput("t4_reload_out", out, 1'b1);

    $display("[TB] latch and read");
    doCtrl(3'b000, 2'b11);
    doData(8'h40);
    doData(8'h12);
    doTick(13);
    checkOutput("t5_count", count, 16'h1234);
    doCtrl(3'b000, 2'b00);
    doTick(5);
    checkOutput("t5_live", count, 16'h122F);
    doRead();
    checkOutput("t5_rd_lsb", data_out, 8'h34);
    doRead();
    checkOutput("t5_rd_msb", data_out, 8'h12);
    doRead();
    checkOutput("t5_rd_live", data_out, 8'h2F);

    $display("[TB] async reset mid-count");
    doCtrl(3'b010, 2'b11);
    doData(8'h00);
    doData(8'h01);
    doTick(1);
    checkOutput("t1_count", count, 16'h0100);
    doRead();
    doRead();
    #2 rst_n = 0;
    #1;
    modelReset();
    checkOutput("t1_out", out, 1'b0);
    checkOutput("t1_count_rst", count, 16'h0000);
    checkOutput("t1_busy", busy, 1'b0);
    checkOutput("t1_data_out", data_out, 8'h00);
    #3 rst_n = 1;
    @(posedge clk);
    #1;
    doTick(2);
    checkOutput("t1_idle_count", count, 16'h0000);

    $display("[TB] random traffic");
    for (int i = 0; i < 800; i++) begin
      r_cw  = ($urandom_range(0, 19) == 0);
      r_cm  = 3'($urandom);
      r_rw  = 2'($urandom);
      r_dw  = ($urandom_range(0, 9) == 0);
      r_din = 8'($urandom_range(0, 6));
      r_rr  = ($urandom_range(0, 5) == 0);
      r_tk  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 24) == 0) gate = ~gate;
      applyStimulus(r_cw, r_cm, r_rw, r_dw, r_din, r_rr, r_tk);
    end

    $display("[TB] control/data collision and zero load");
    gate = 1;
    applyStimulus(1, 3'b000, 2'b11, 1, 8'h77, 0, 0);
    checkOutput("t6_busy", busy, 1'b0);
    doTick(1);
    checkOutput("t6_idle_busy", busy, 1'b0);
    doData(8'h00);
    doData(8'h00);
    checkOutput("t6_armed", busy, 1'b1);
    check_each = 0;
    doTick(1);
    checkOutput("t6_load", count, 16'h0000);
    doTick(65535);
    checkOutput("t6_count_1", count, 16'h0001);
    checkOutput("t6_out_low", out, 1'b0);
    doTick(1);
    checkOutput("t6_term_count", count, 16'h0000);
    checkOutput("t6_term_out", out, 1'b1);
    checkOutput("t6_term_busy", busy, 1'b0);
    checkOutput("t6_model_count", count, m_count);
    check_each = 1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
